// File: rtl/msm_pkg.sv
// msm_pkg: shared widths, payload structs and FSM encoding for the MSM
// point-fetch slice.
//   point_t : one curve point {x, y, z}
//   tuple_t : one streamed tuple {point, scalar k, ordinal index, last flag}
//   state_e : read-initiator FSM states
package msm_pkg;

    localparam int EC_BASE_FIELD_WIDTH   = 377;
    localparam int EC_SCALAR_FIELD_WIDTH = 253;
    localparam int ADDR_WIDTH            = 4;
    localparam int MEM_SIZE              = 16;
    localparam int IDX_W                 = ADDR_WIDTH + 1;

    typedef struct packed {
        logic [EC_BASE_FIELD_WIDTH-1:0] x;
        logic [EC_BASE_FIELD_WIDTH-1:0] y;
        logic [EC_BASE_FIELD_WIDTH-1:0] z;
    } point_t;

    typedef struct packed {
        point_t                           pt;
        logic [EC_SCALAR_FIELD_WIDTH-1:0] k;
        logic [IDX_W-1:0]                 index;
        logic                             last;
    } tuple_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/msm_tuple_fifo2.sv
// msm_tuple_fifo2: 2-entry FIFO of tuple_t.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write one tuple (caller guarantees space)
//   pop        : drop the head entry (caller guarantees non-empty)
//   dout       : head entry
//   count      : occupancy 0..2
// A simultaneous push and pop leaves the occupancy unchanged.
module msm_tuple_fifo2
    import msm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  tuple_t     din,
    input  logic       pop,
    output tuple_t     dout,
    output logic [1:0] count
);

    tuple_t     mem_q [2];
    tuple_t     mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/msm_point_fetch.sv
// msm_point_fetch: ap_memory read initiator for the P_arr_x/y/z_V and K_arr_V
// test-case memories. On ap_start it reads num_points consecutive tuples from
// base_addr (address wraps mod 2^ADDR_WIDTH, read latency 1) and streams them
// on out_* (valid/ready) through a 2-entry buffer.
//   ap_clk/ap_rst_n        : clock, asynchronous active-low reset
//   ap_start/done/idle/ready : block-level handshake
//   base_addr, num_points  : run parameters, latched at start
//   *_address0/ce0/we0/q0  : port-0 memory interfaces (we0 tied low)
//   out_*                  : tuple stream {x, y, z, k, index, last}
// Optional macro PERF_CNT_EN adds stall_cycles: count of cycles with
// out_valid && !out_ready, cleared on an accepted start, saturating.
module msm_point_fetch
    import msm_pkg::*;
(
    input  logic                             ap_clk,
    input  logic                             ap_rst_n,
    input  logic                             ap_start,
    output logic                             ap_done,
    output logic                             ap_idle,
    output logic                             ap_ready,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [IDX_W-1:0]                 num_points,
    output logic [ADDR_WIDTH-1:0]            P_arr_x_V_address0,
    output logic                             P_arr_x_V_ce0,
    output logic                             P_arr_x_V_we0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_x_V_q0,
    output logic [ADDR_WIDTH-1:0]            P_arr_y_V_address0,
    output logic                             P_arr_y_V_ce0,
    output logic                             P_arr_y_V_we0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_y_V_q0,
    output logic [ADDR_WIDTH-1:0]            P_arr_z_V_address0,
    output logic                             P_arr_z_V_ce0,
    output logic                             P_arr_z_V_we0,
    input  logic [EC_BASE_FIELD_WIDTH-1:0]   P_arr_z_V_q0,
    output logic [ADDR_WIDTH-1:0]            K_arr_V_address0,
    output logic                             K_arr_V_ce0,
    output logic                             K_arr_V_we0,
    input  logic [EC_SCALAR_FIELD_WIDTH-1:0] K_arr_V_q0,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_x,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_y,
    output logic [EC_BASE_FIELD_WIDTH-1:0]   out_z,
    output logic [EC_SCALAR_FIELD_WIDTH-1:0] out_k,
    output logic [IDX_W-1:0]                 out_index,
    output logic                             out_last
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]                      stall_cycles
`endif
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [IDX_W-1:0]      num_q, num_d;
    logic [IDX_W-1:0]      issued_q, issued_d;
    logic                  inflight_q, inflight_d;
    logic [IDX_W-1:0]      infl_idx_q, infl_idx_d;
    logic                  infl_last_q, infl_last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic       issue, last_issue, pop, start_acc;
    logic [1:0] fifo_cnt;
    logic [2:0] occ;
    tuple_t     head, push_data;

    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign start_acc = (state_q == ST_IDLE) && ap_start;

    // Effective occupancy: an entry popped this cycle frees its slot before
    // the read issued now can land (two edges later), so it earns credit back.
    // This keeps 1 tuple/cycle with out_ready held high.
    assign occ = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};

    // ---- FSM: state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // ---- FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ap_start) state_d = (num_points == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: if (last_issue) state_d = ST_DRAIN;
            // Leave as soon as the final tuple is being accepted, so ap_done
            // lands the cycle after that accept.
            ST_DRAIN: if (!inflight_q && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop)))
                          state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs
    always_comb begin
        ap_idle    = (state_q == ST_IDLE);
        ap_done    = (state_q == ST_DONE);
        issue      = (state_q == ST_FETCH) && (occ < 3'd2);
        last_issue = issue && (issued_q == num_q - IDX_W'(1));
        ap_ready   = last_issue;
    end

    // ---- datapath
    always_comb begin
        base_d      = base_q;
        num_d       = num_q;
        issued_d    = issued_q;
        infl_idx_d  = infl_idx_q;
        infl_last_d = infl_last_q;
        addr_d      = addr_q;
        inflight_d  = issue;
        if (start_acc) begin
            base_d   = base_addr;
            num_d    = num_points;
            issued_d = '0;
        end
        if (issue) begin
            issued_d    = issued_q + IDX_W'(1);
            infl_idx_d  = issued_q;
            infl_last_d = last_issue;
            addr_d      = base_q + issued_q[ADDR_WIDTH-1:0];  // wraps naturally
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            base_q      <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            inflight_q  <= 1'b0;
            infl_idx_q  <= '0;
            infl_last_q <= 1'b0;
            addr_q      <= '0;
        end else begin
            base_q      <= base_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            inflight_q  <= inflight_d;
            infl_idx_q  <= infl_idx_d;
            infl_last_q <= infl_last_d;
            addr_q      <= addr_d;
        end
    end

    // Memory ports: address is live with ce0 and holds its last value otherwise.
    always_comb begin
        P_arr_x_V_address0 = addr_d;
        P_arr_y_V_address0 = addr_d;
        P_arr_z_V_address0 = addr_d;
        K_arr_V_address0   = addr_d;
        P_arr_x_V_ce0      = issue;
        P_arr_y_V_ce0      = issue;
        P_arr_z_V_ce0      = issue;
        K_arr_V_ce0        = issue;
        P_arr_x_V_we0      = 1'b0;
        P_arr_y_V_we0      = 1'b0;
        P_arr_z_V_we0      = 1'b0;
        K_arr_V_we0        = 1'b0;
    end

    always_comb begin
        push_data.pt.x  = P_arr_x_V_q0;
        push_data.pt.y  = P_arr_y_V_q0;
        push_data.pt.z  = P_arr_z_V_q0;
        push_data.k     = K_arr_V_q0;
        push_data.index = infl_idx_q;
        push_data.last  = infl_last_q;
    end

    msm_tuple_fifo2 u_fifo (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .push  (inflight_q),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .count (fifo_cnt)
    );

    assign out_x     = head.pt.x;
    assign out_y     = head.pt.y;
    assign out_z     = head.pt.z;
    assign out_k     = head.k;
    assign out_index = out_valid ? head.index : '0;
    assign out_last  = out_valid && head.last;

`ifdef PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_acc)
            stall_d = '0;
        else if (out_valid && !out_ready && stall_q != '1)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) stall_q <= '0;
        else           stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_msm_point_fetch.sv
module tb_msm_point_fetch;
    import msm_pkg::*;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    logic ap_start = 1'b0;
    logic ap_done, ap_idle, ap_ready;
    logic [ADDR_WIDTH-1:0] base_addr = '0;
    logic [IDX_W-1:0]      num_points = '0;
    logic [ADDR_WIDTH-1:0] ax, ay, az, ak;
    logic cx, cy, cz, ck, wx, wy, wz, wk;
    logic [EC_BASE_FIELD_WIDTH-1:0]   qx, qy, qz;
    logic [EC_SCALAR_FIELD_WIDTH-1:0] qk;
    logic out_valid, out_last;
    logic out_ready = 1'b0;
    logic [EC_BASE_FIELD_WIDTH-1:0]   out_x, out_y, out_z;
    logic [EC_SCALAR_FIELD_WIDTH-1:0] out_k;
    logic [IDX_W-1:0]                 out_index;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int overflow_cnt = 0;

    logic [EC_BASE_FIELD_WIDTH-1:0]   mx [MEM_SIZE];
    logic [EC_BASE_FIELD_WIDTH-1:0]   my [MEM_SIZE];
    logic [EC_BASE_FIELD_WIDTH-1:0]   mz [MEM_SIZE];
    logic [EC_SCALAR_FIELD_WIDTH-1:0] mk [MEM_SIZE];

    always #5 ap_clk = ~ap_clk;

    msm_point_fetch dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .base_addr(base_addr), .num_points(num_points),
        .P_arr_x_V_address0(ax), .P_arr_x_V_ce0(cx), .P_arr_x_V_we0(wx), .P_arr_x_V_q0(qx),
        .P_arr_y_V_address0(ay), .P_arr_y_V_ce0(cy), .P_arr_y_V_we0(wy), .P_arr_y_V_q0(qy),
        .P_arr_z_V_address0(az), .P_arr_z_V_ce0(cz), .P_arr_z_V_we0(wz), .P_arr_z_V_q0(qz),
        .K_arr_V_address0(ak), .K_arr_V_ce0(ck), .K_arr_V_we0(wk), .K_arr_V_q0(qk),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_k(out_k),
        .out_index(out_index), .out_last(out_last)
`ifdef PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    // Synchronous-read memories, latency 1, each driven by its own port.
    always @(posedge ap_clk) begin
        if (cx) qx <= mx[ax];
        if (cy) qy <= my[ay];
        if (cz) qz <= mz[az];
        if (ck) qk <= mk[ak];
    end

    // Buffer overflow watch: a push into a full buffer without a pop.
    always @(posedge ap_clk)
        if (ap_rst_n && dut.u_fifo.push && !dut.u_fifo.pop && dut.u_fifo.count == 2'd2)
            overflow_cnt++;

    task automatic chk(input string tag, input logic [376:0] obs, input logic [376:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [376:0] rw();
        logic [376:0] r = '0;
        for (int i = 0; i < 12; i++) r = {r[344:0], $urandom()};
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < MEM_SIZE; i++) begin
            mx[i] = rw(); my[i] = rw(); mz[i] = rw();
            mk[i] = rw()[252:0];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idle"},  377'(ap_idle), 377'(1));
        chk({tag, "_done"},  377'(ap_done), 377'(0));
        chk({tag, "_ready"}, 377'(ap_ready), 377'(0));
        chk({tag, "_ce"},    377'({cx, cy, cz, ck}), 377'(0));
        chk({tag, "_we"},    377'({wx, wy, wz, wk}), 377'(0));
        chk({tag, "_addr"},  377'({ax, ay, az, ak}), 377'(0));
        chk({tag, "_valid"}, 377'(out_valid), 377'(0));
        chk({tag, "_last"},  377'(out_last), 377'(0));
        chk({tag, "_index"}, 377'(out_index), 377'(0));
`ifdef PERF_CNT_EN
        chk({tag, "_stall"}, 377'(stall_cycles), 377'(0));
`endif
    endtask

    // One run. Interval k is the cycle after the k-th posedge following the
    // start edge (k=0 is the cycle right after ap_start was sampled).
    task automatic run(input string tag, input int base, input int n, input int rdy_pct,
                       input bit glitch, input int abort_at);
        int got, first_v, ready_k, done_k, last_acc, n_ce, stalls;
        bit pv, pr;
        logic [376:0] px, py, pz, pk;
        int addrs [$];
        got = 0; first_v = -1; ready_k = -1; done_k = -1; last_acc = -1;
        n_ce = 0; stalls = 0; pv = 0; pr = 0; px = '0; py = '0; pz = '0; pk = '0;

        @(posedge ap_clk); #1;
        ap_start = 1'b1; base_addr = base[ADDR_WIDTH-1:0]; num_points = n[IDX_W-1:0];
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        base_addr = ADDR_WIDTH'($urandom); num_points = IDX_W'($urandom);

        for (int k = 0; k < 300; k++) begin
            if (glitch && k == 3) begin
                ap_start = 1'b1; base_addr = ~base[ADDR_WIDTH-1:0]; num_points = 5'd2;
            end
            if (glitch && k == 4) ap_start = 1'b0;
            out_ready = ($urandom_range(99) < rdy_pct);
            @(negedge ap_clk);
            if (cx) begin n_ce++; addrs.push_back(int'(ax)); end
            if (ap_ready) ready_k = k;
            if (out_valid && first_v < 0) first_v = k;
            if (pv && !pr) begin
                chk({tag, "_hold_valid"}, 377'(out_valid), 377'(1));
                chk({tag, "_hold_x"}, out_x, px);
                chk({tag, "_hold_k"}, 377'(out_k), pk);
            end
            pv = out_valid; pr = out_ready;
            px = out_x; py = out_y; pz = out_z; pk = 377'(out_k);
            if (out_valid && !out_ready) stalls++;
            if (out_valid && out_ready) begin
                int a;
                a = (base + got) % MEM_SIZE;
                chk({tag, "_x"}, out_x, mx[a]);
                chk({tag, "_y"}, out_y, my[a]);
                chk({tag, "_z"}, out_z, mz[a]);
                chk({tag, "_k"}, 377'(out_k), 377'(mk[a]));
                chk({tag, "_idx_last"}, 377'({out_index, out_last}),
                    377'({got[IDX_W-1:0], got == n - 1}));
                got++; last_acc = k;
                if (abort_at > 0 && got == abort_at) begin
                    @(posedge ap_clk); #1;
                    return;
                end
            end
            if (ap_done) begin done_k = k; break; end
            @(posedge ap_clk); #1;
        end

        chk({tag, "_done_seen"}, 377'(done_k >= 0), 377'(1));
        chk({tag, "_count"}, 377'(got), 377'(n));
        chk({tag, "_reads"}, 377'(n_ce), 377'(n));
        for (int i = 0; i < addrs.size() && i < n; i++)
            chk({tag, "_addr"}, 377'(addrs[i]), 377'((base + i) % MEM_SIZE));
        if (n == 0) begin
            chk({tag, "_done_k"}, 377'(done_k), 377'(0));
            chk({tag, "_no_valid"}, 377'(first_v), 377'(-1));
        end else begin
            chk({tag, "_first_valid"}, 377'(first_v), 377'(2));
            chk({tag, "_done_after_last"}, 377'(done_k), 377'(last_acc + 1));
            chk({tag, "_ready_before_done"}, 377'(ready_k >= 0 && ready_k < done_k), 377'(1));
            if (rdy_pct == 100) begin
                chk({tag, "_last_acc"}, 377'(last_acc), 377'(n + 1));
                chk({tag, "_ready_k"}, 377'(ready_k), 377'(n - 1));
            end
        end
`ifdef PERF_CNT_EN
        chk({tag, "_stalls"}, 377'(stall_cycles), 377'(stalls));
`endif
        @(negedge ap_clk);
        chk({tag, "_back_idle"}, 377'(ap_idle), 377'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        #2;
        check_reset_outputs("rst");
        @(negedge ap_clk); ap_rst_n = 1'b1;

        // Patterned memory, full throughput
        for (int i = 0; i < MEM_SIZE; i++) begin
            mx[i] = 377'(i); my[i] = 377'(i + 100); mz[i] = 377'(1); mk[i] = 253'(i * 3);
        end
        run("full16", 0, 16, 100, 1'b0, 0);

        run("zero", 5, 0, 100, 1'b0, 0);

        fill_random();
        run("wrap", 14, 4, 100, 1'b0, 0);

        fill_random();
        run("bp50", int'($urandom_range(15)), 10, 50, 1'b0, 0);

        // Reset mid-fetch after three accepts, then a fresh run
        fill_random();
        run("abort", 2, 12, 100, 1'b0, 3);
        ap_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge ap_clk); ap_rst_n = 1'b1;
        run("restart", int'($urandom_range(15)), 5, 100, 1'b0, 0);

        fill_random();
        run("glitch", 3, 8, 100, 1'b1, 0);

        chk("no_overflow", 377'(overflow_cnt), 377'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
